mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ read requesters onto one mem_wrapper read port.
// Define MEM_ARB_TIMEOUT_EN to build the read-response watchdog (TIMEOUT_CYCLES).
module mem_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [DATA_WIDTH-1:0]         mem_readdata,
  input  logic                          mem_readdatavalid,
  input  logic                          mem_waitrequest
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_badNumReq
    $error("mem_read_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
    $error("mem_read_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;

  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          r_lastGrant;
  logic [ADDR_WIDTH-1:0]  r_memAddress;
  logic [NUM_REQ-1:0]     r_rspValid;
  logic [DATA_WIDTH-1:0]  r_rspData;

  logic                   w_hiFound;
  logic [GW-1:0]          w_hiIdx;
  logic                   w_loFound;
  logic [GW-1:0]          w_loIdx;
  logic                   w_winFound;
  logic [GW-1:0]          w_winIdx;
  logic [ADDR_WIDTH-1:0]  w_selAddr;
  logic                   w_accept;
  logic                   w_rspDone;
  logic                   w_timeout;
  logic [NUM_REQ-1:0]     w_grantOneHot;

  // Prefer the lowest active requester above last_grant; otherwise wrap to the lowest overall.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loFound = 1'b0;
    w_loIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_loFound = 1'b1;
        w_loIdx   = GW'(i);
        if (i > int'(r_lastGrant)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = GW'(i);
        end
      end
    end
    w_winFound = w_loFound;
    w_winIdx   = w_hiFound ? w_hiIdx : w_loIdx;
  end

  always_comb begin
    w_selAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winIdx == GW'(i)) begin
        w_selAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_accept      = (r_state == IDLE) && w_winFound;
  assign w_rspDone     = (r_state == WAIT) && mem_readdatavalid;
  assign w_grantOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] r_waitCnt;
  logic        r_rspErr;

  // Counter sits at zero outside WAIT, so it is already clear on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state != WAIT) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= r_waitCnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == WAIT) && !mem_readdatavalid &&
                     (r_waitCnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspErr <= 1'b0;
    end else begin
      r_rspErr <= w_timeout;
    end
  end

  assign rsp_err = r_rspErr;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ISSUE;
      ISSUE:   if (!mem_waitrequest) w_nextState = WAIT;
      WAIT:    if (w_rspDone || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winIdx;
    end
    busy        = (r_state != IDLE);
    mem_read    = (r_state == ISSUE);
    mem_address = r_memAddress;
    rsp_valid   = r_rspValid;
    rsp_data    = r_rspData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= '0;
      r_lastGrant  <= GW'(NUM_REQ - 1);
      r_memAddress <= '0;
    end else if (w_accept) begin
      r_grant      <= w_winIdx;
      r_lastGrant  <= w_winIdx;
      r_memAddress <= w_selAddr;
    end
  end

  // Response strobe lasts one cycle; data holds until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else begin
      r_rspValid <= '0;
      if (w_rspDone) begin
        r_rspValid <= w_grantOneHot;
        r_rspData  <= mem_readdata;
      end else if (w_timeout) begin
        r_rspValid <= w_grantOneHot;
        r_rspData  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized self-checking bench for mem_read_arbiter against a transaction-level model.
// Compile with MEM_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_mem_read_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int TMO  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [AW-1:0]    mem_address;
  logic             mem_read;
  logic [DW-1:0]    mem_readdata;
  logic             mem_readdatavalid;
  logic             mem_waitrequest;

  int               vectorCount = 0;
  int               missCount   = 0;
  int               modelLastGrant;
  logic [DW-1:0]    modelRspData;
  logic [AW-1:0]    addrTable [NREQ];

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .mem_waitrequest(mem_waitrequest)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin choice: first requester found walking upward from the one after last grant.
  function automatic int modelPick(input logic [NREQ-1:0] pat);
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (modelLastGrant + k) % NREQ;
      if (pat[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oneHot(input int idx);
    logic [NREQ-1:0] v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] pat);
    req_valid = pat;
    for (int i = 0; i < NREQ; i++) begin
      addrTable[i] = $urandom;
      req_addr[i*AW +: AW] = addrTable[i];
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge where the response is visible.
  task automatic runTxn(input logic [NREQ-1:0] pat, input int stall, input int lat,
                        input bit stray, input bit tmo, input bit fixed,
                        input logic [AW-1:0] fixAddr, input logic [DW-1:0] fixData);
    int win;
    logic [DW-1:0] d;
    logic [NREQ-1:0] decoy;
    if ($urandom_range(0, 1) == 1) begin
      decoy = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      applyStimulus(decoy);
      #1;
      checkOutput("ready_decoy", req_ready, oneHot(modelPick(decoy)));
    end
    applyStimulus(pat);
    if (fixed) begin
      addrTable[0] = fixAddr;
      req_addr[AW-1:0] = fixAddr;
    end
    win = modelPick(pat);
    #1;
    checkOutput("ready", req_ready, oneHot(win));
    checkOutput("busy_idle", busy, 1'b0);
    @(negedge clk);
    req_valid = '0;
    modelLastGrant = win;
    checkOutput("ready_busy", req_ready, '0);
    checkOutput("rsp_valid_accept", rsp_valid, '0);
    checkOutput("rsp_data_hold", rsp_data, modelRspData);
    for (int s = 0; s <= stall; s++) begin
      checkOutput("mem_read_issue", mem_read, 1'b1);
      checkOutput("mem_addr", mem_address, addrTable[win]);
      checkOutput("busy_issue", busy, 1'b1);
      mem_waitrequest   = (s < stall);
      mem_readdatavalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_readdata      = {$urandom, $urandom};
      @(negedge clk);
    end
    mem_readdatavalid = 1'b0;
    mem_waitrequest   = 1'($urandom_range(0, 1));
    if (tmo) begin
      for (int w = 0; w < TMO; w++) begin
        checkOutput("mem_read_wait", mem_read, 1'b0);
        checkOutput("rsp_valid_wait", rsp_valid, '0);
        checkOutput("busy_wait", busy, 1'b1);
        @(negedge clk);
      end
      modelRspData = '0;
      checkOutput("rsp_valid_tmo", rsp_valid, oneHot(win));
      checkOutput("rsp_err_tmo", rsp_err, 1'b1);
      checkOutput("rsp_data_tmo", rsp_data, modelRspData);
    end else begin
      for (int w = 0; w < lat; w++) begin
        checkOutput("mem_read_wait", mem_read, 1'b0);
        checkOutput("rsp_valid_wait", rsp_valid, '0);
        @(negedge clk);
      end
      d = fixed ? fixData : {$urandom, $urandom};
      mem_readdatavalid = 1'b1;
      mem_readdata      = d;
      @(negedge clk);
      mem_readdatavalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_readdata      = {$urandom, $urandom};
      modelRspData = d;
      checkOutput("rsp_valid", rsp_valid, oneHot(win));
      checkOutput("rsp_err", rsp_err, 1'b0);
      checkOutput("rsp_data", rsp_data, modelRspData);
    end
    checkOutput("busy_done", busy, 1'b0);
  endtask

  task automatic idleCycles(input int n, input bit strayAll);
    for (int c = 0; c < n; c++) begin
      req_valid = '0;
      mem_readdatavalid = strayAll ? 1'b1 : 1'($urandom_range(0, 1));
      mem_readdata = {$urandom, $urandom};
      #1;
      checkOutput("ready_idle", req_ready, '0);
      checkOutput("mem_read_idle", mem_read, 1'b0);
      @(negedge clk);
      checkOutput("rsp_valid_idle", rsp_valid, '0);
      checkOutput("rsp_data_idle", rsp_data, modelRspData);
      checkOutput("busy_idle_gap", busy, 1'b0);
    end
    mem_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    mem_readdata = '0;
    mem_readdatavalid = 1'b0;
    mem_waitrequest = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_mem_read", mem_read, 1'b0);
    checkOutput("rst_mem_addr", mem_address, '0);
    checkOutput("rst_rsp_valid", rsp_valid, '0);
    checkOutput("rst_rsp_data", rsp_data, '0);
    checkOutput("rst_rsp_err", rsp_err, 1'b0);
    checkOutput("rst_ready", req_ready, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelLastGrant = NREQ - 1;
    modelRspData = '0;
    @(negedge clk);

    // Contention between requesters 0 and 1, including the back-to-back accept on the response cycle.
    for (int t = 0; t < 4; t++) runTxn(3'b011, 0, 1, 1'b0, 1'b0, 1'b0, '0, '0);
    idleCycles(1, 1'b0);

    runTxn(3'b001, 0, 2, 1'b0, 1'b0, 1'b1, 32'h10, 64'h1122334455667788);
    runTxn(3'b001, 5, 1, 1'b1, 1'b0, 1'b0, '0, '0);
    runTxn(3'b001, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    idleCycles(2, 1'b1);

    // Reset while waiting for read data abandons the read.
    applyStimulus(3'b010);
    @(negedge clk);
    req_valid = '0;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_mem_read", mem_read, 1'b0);
    checkOutput("midrst_mem_addr", mem_address, '0);
    checkOutput("midrst_rsp_valid", rsp_valid, '0);
    checkOutput("midrst_rsp_data", rsp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    modelLastGrant = NREQ - 1;
    modelRspData = '0;
    mem_readdatavalid = 1'b1;
    mem_readdata = {$urandom, $urandom};
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    checkOutput("postrst_rsp_valid", rsp_valid, '0);
    checkOutput("postrst_busy", busy, 1'b0);
    runTxn(3'b111, 1, 1, 1'b0, 1'b0, 1'b0, '0, '0);

`ifdef MEM_ARB_TIMEOUT_EN
    runTxn(3'b100, 0, 0, 1'b0, 1'b1, 1'b0, '0, '0);
    idleCycles(1, 1'b1);
    runTxn(3'b110, 2, 0, 1'b1, 1'b1, 1'b0, '0, '0);
`endif

    for (int t = 0; t < 40; t++) begin
      runTxn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 4),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2), 1'b0);
    end
    idleCycles(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
